// File: rtl/cr_huf_comp_ph_fetch_if.sv
// PH-stage read/response bus plus the output word stream of the table fetcher.
// The fetcher uses master and the PH stage / header writer side uses slave.
interface cr_huf_comp_ph_fetch_if #(
  parameter int DATA_W  = 60,
  parameter int ADDR_W  = 6,
  parameter int SEQID_W = 3
) ();
  logic               ph_rd;
  logic [ADDR_W-1:0]  ph_addr;
  logic [SEQID_W-1:0] ph_seq_id;
  logic               ph_val;
  logic [DATA_W-1:0]  ph_dpth;
  logic               out_vld;
  logic               out_rdy;
  logic [DATA_W-1:0]  out_data;
  logic               out_last;

  modport master (
    output ph_rd, ph_addr, ph_seq_id, out_vld, out_data, out_last,
    input  ph_val, ph_dpth, out_rdy
  );

  modport slave (
    input  ph_rd, ph_addr, ph_seq_id, out_vld, out_data, out_last,
    output ph_val, ph_dpth, out_rdy
  );
endinterface

// File: rtl/cr_huf_comp_ph_fetch.sv
// PH table fetcher: walks entries 0..num-1, credit-limited reads, FWFT response buffer.
// First word 1 + PH round-trip + 1 cycles after issue; out_rdy low stalls issue via credits.
module cr_huf_comp_ph_fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_rdy,
  output logic          rd_vld,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_vld) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr_vld) - CW'(pop);
    end
  end
endmodule

module cr_huf_comp_ph_fetch #(
  parameter int DATA_W      = 60,
  parameter int ADDR_W      = 6,
  parameter int SEQID_W     = 3,
  parameter int MAX_ENTRIES = 48,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SEQID_W-1:0] start_seq_id,
  input  logic [ADDR_W:0]    start_num,
  output logic               busy,
  output logic               done,
  output logic               err_unexp_val,
  output logic               err_num_range,
  cr_huf_comp_ph_fetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] MAX_N   = (ADDR_W + 1)'(MAX_ENTRIES);
  localparam logic [CW:0]     DEPTH_N = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W:0]   num_q, issue_cnt, rcv_cnt, num_m1;
  logic [CW-1:0]     outstanding, fifo_cnt;
  logic              accept, issue_now, push, pop, credit_ok, zero_done;
  logic              fifo_vld, head_last;
  logic [DATA_W-1:0] head_data;

  assign num_m1    = num_q - (ADDR_W + 1)'(1);
  assign accept    = (state == IDLE) && start && (start_num != '0);
  assign push      = bus.ph_val && (outstanding != '0);
  assign pop       = bus.out_vld && bus.out_rdy;
  // A pop this cycle frees a slot long before any new request can return.
  assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, outstanding}) < (DEPTH_N + (CW + 1)'(pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_now = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: if (credit_ok) begin
        issue_now = 1'b1;
        if (issue_cnt == num_m1) state_nxt = DRAIN;
      end
      DRAIN: if (pop && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q         <= '0;
      issue_cnt     <= '0;
      rcv_cnt       <= '0;
      outstanding   <= '0;
      zero_done     <= 1'b0;
      err_unexp_val <= 1'b0;
      err_num_range <= 1'b0;
      bus.ph_rd     <= 1'b0;
      bus.ph_addr   <= '0;
      bus.ph_seq_id <= '0;
    end else begin
      zero_done <= (state == IDLE) && start && (start_num == '0);
      if (accept) begin
        bus.ph_seq_id <= start_seq_id;
        num_q         <= (start_num > MAX_N) ? MAX_N : start_num;
        issue_cnt     <= '0;
        rcv_cnt       <= '0;
        if (start_num > MAX_N) err_num_range <= 1'b1;
      end
      bus.ph_rd <= issue_now;
      if (issue_now) begin
        bus.ph_addr <= issue_cnt[ADDR_W-1:0];
        issue_cnt   <= issue_cnt + (ADDR_W + 1)'(1);
      end
      if (push) rcv_cnt <= rcv_cnt + (ADDR_W + 1)'(1);
      if (bus.ph_val && (outstanding == '0)) err_unexp_val <= 1'b1;
      outstanding <= outstanding + CW'(issue_now) - CW'(push);
    end
  end

  cr_huf_comp_ph_fetch_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat ({rcv_cnt == num_m1, bus.ph_dpth}),
    .rd_rdy (bus.out_rdy),
    .rd_vld (fifo_vld),
    .rd_dat ({head_last, head_data}),
    .count  (fifo_cnt)
  );

  assign bus.out_vld  = fifo_vld;
  assign bus.out_data = fifo_vld ? head_data : '0;
  assign bus.out_last = fifo_vld && head_last;
  assign busy         = (state != IDLE);
  assign done         = zero_done || (pop && head_last);
endmodule
